// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad direction scanner.
// Holds FSM states, direction encodings, key codes and a column resolver.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_MID   = 4'd5;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd9;

  localparam logic [3:0] COL_IDLE  = 4'hF;

  // Lowest active-low column wins when several are pressed.
  function automatic logic [1:0] low_col(
    input logic [3:0] c
  );
    logic [1:0] idx;
    idx = 2'd3;
    if (!c[2]) idx = 2'd2;
    if (!c[1]) idx = 2'd1;
    if (!c[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_slot_timer.sv
// Row-slot timer: counts 0..SCAN_DIV-1 and flags the last cycle.
// Ports: clk, rst_n, tick_o (high while the counter is at SCAN_DIV-1).
module keypad_slot_timer
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);
  assign cnt_d  = tick_o ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_dir_scan.sv
// 4x4 keypad scanner with debounce and a direction map for a game stage.
// Ports: clk, rst_n, col (in), row, vir, hor, key_code, key_valid (out).
// Build option: KEYPAD_AUTOREPEAT_EN adds auto-repeat while a key is held.
module keypad_dir_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [1:0] vir,
  output logic [1:0] hor,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_N - 1);

  logic       tick;
  logic [3:0] col_s1_q;
  logic [3:0] col_s2_q;
  logic       idle;

  state_e     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] samp_q, samp_d;
  logic       fire;
  logic [3:0] new_code;

  logic [1:0] vir_q, vir_d;
  logic [1:0] hor_q, hor_d;
  logic [3:0] code_q, code_d;
  logic       kv_q, kv_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [6:0] REP_LAST = 7'(8 * DEBOUNCE_N - 1);
  logic [6:0] rep_q, rep_d;
`endif

  keypad_slot_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
    end
  end

  assign idle     = (col_s2_q == COL_IDLE);
  assign new_code = {row_q, low_col(samp_q)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      row_q   <= 2'd0;
      deb_q   <= 4'd0;
      samp_q  <= 4'hF;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= 7'd0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      deb_q   <= deb_d;
      samp_q  <= samp_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    deb_d   = deb_q;
    samp_d  = samp_q;
    fire    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (idle) begin
            row_d = row_q + 2'd1;
          end else begin
            samp_d  = col_s2_q;
            deb_d   = 4'd1;
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (col_s2_q == samp_q) begin
            if (deb_q == DEB_LAST) begin
              state_d = HELD;
              deb_d   = 4'd0;
              fire    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = 7'd0;
`endif
            end else begin
              deb_d = deb_q + 4'd1;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_q + 2'd1;
            deb_d   = 4'd0;
          end
        end
        HELD: begin
          if (idle) begin
            state_d = DEB_REL;
            deb_d   = 4'd1;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_q == REP_LAST) begin
              rep_d = 7'd0;
              fire  = 1'b1;
            end else begin
              rep_d = rep_q + 7'd1;
            end
`endif
          end
        end
        DEB_REL: begin
          if (idle) begin
            if (deb_q == DEB_LAST) begin
              state_d = SCAN;
              row_d   = row_q + 2'd1;
              deb_d   = 4'd0;
            end else begin
              deb_d = deb_q + 4'd1;
            end
          end else begin
            // Bounce during release: back to held, no new pulse.
            state_d = HELD;
            deb_d   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = 7'd0;
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    kv_d   = fire;
    code_d = code_q;
    vir_d  = vir_q;
    hor_d  = hor_q;
    if (fire) begin
      code_d = new_code;
      case (new_code)
        KEY_UP: begin
          vir_d = DIR_UP;
          hor_d = DIR_NONE;
        end
        KEY_DOWN: begin
          vir_d = DIR_DOWN;
          hor_d = DIR_NONE;
        end
        KEY_LEFT: begin
          vir_d = DIR_NONE;
          hor_d = DIR_LEFT;
        end
        KEY_RIGHT: begin
          vir_d = DIR_NONE;
          hor_d = DIR_RIGHT;
        end
        KEY_MID: begin
          vir_d = DIR_NONE;
          hor_d = DIR_NONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vir_q  <= DIR_NONE;
      hor_q  <= DIR_NONE;
      code_q <= 4'd0;
      kv_q   <= 1'b0;
    end else begin
      vir_q  <= vir_d;
      hor_q  <= hor_d;
      code_q <= code_d;
      kv_q   <= kv_d;
    end
  end

  assign row       = ~(4'b0001 << row_q);
  assign vir       = vir_q;
  assign hor       = hor_q;
  assign key_code  = code_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_dir_scan.sv
// Directed bench for keypad_dir_scan with SCAN_DIV=4, DEBOUNCE_N=3.
// Define KEYPAD_AUTOREPEAT_EN to also exercise the auto-repeat steps.
module tb_keypad_dir_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [1:0] vir;
  logic [1:0] hor;
  logic [3:0] key_code;
  logic       key_valid;

  int n_assert;
  int n_fail;
  int pulses;

  logic [3:0] rp [4];

  keypad_dir_scan #(
    .SCAN_DIV  (4),
    .DEBOUNCE_N(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .row      (row),
    .vir      (vir),
    .hor      (hor),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial pulses = 0;
  always @(negedge clk) if (key_valid === 1'b1) pulses = pulses + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rp[0] = 4'b1110;
    rp[1] = 4'b1101;
    rp[2] = 4'b1011;
    rp[3] = 4'b0111;
    rst_n = 1'b0;
    col   = 4'hF;
    step(2);
    chk("rst_row", 8'(row), 8'h0E);
    chk("rst_vir", 8'(vir), 8'h00);
    chk("rst_hor", 8'(hor), 8'h00);
    chk("rst_code", 8'(key_code), 8'h00);
    chk("rst_kv", 8'(key_valid), 8'h00);

    // Idle scan, 40 cycles.
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(4);
      chk("idle_row", 8'(row), 8'(rp[(k + 1) % 4]));
    end
    chk("idle_pulses", 8'(pulses), 8'd0);

    // Key 1: row 0, col 1.
    step(8);
    chk("k1_row0", 8'(row), 8'h0E);
    col = 4'b1101;
    step(4);
    chk("k1_frozen", 8'(row), 8'h0E);
    step(8);
    chk("k1_kv", 8'(key_valid), 8'h01);
    chk("k1_code", 8'(key_code), 8'd1);
    chk("k1_vir", 8'(vir), 8'h01);
    chk("k1_hor", 8'(hor), 8'h00);
    step(1);
    chk("k1_kv_off", 8'(key_valid), 8'h00);
    step(17);
    col = 4'hF;
    step(14);
    chk("k1_rel_row", 8'(row), 8'h0D);
    chk("k1_rel_vir", 8'(vir), 8'h01);
    chk("k1_pulses", 8'(pulses), 8'd1);

    // One-slot glitch on col 2 during row 1.
    col = 4'b1011;
    step(4);
    chk("gl_frozen", 8'(row), 8'h0D);
    col = 4'hF;
    step(4);
    chk("gl_row2", 8'(row), 8'h0B);
    chk("gl_pulses", 8'(pulses), 8'd1);

    // Two columns on row 1 resolve to key 5.
    step(12);
    chk("k5_row1", 8'(row), 8'h0D);
    col = 4'b1001;
    step(12);
    chk("k5_kv", 8'(key_valid), 8'h01);
    chk("k5_code", 8'(key_code), 8'd5);
    chk("k5_vir", 8'(vir), 8'h00);
    chk("k5_hor", 8'(hor), 8'h00);
    col = 4'hF;
    step(12);
    chk("k5_rel_row", 8'(row), 8'h0B);

    // Key 9: row 2, col 1.
    col = 4'b1101;
    step(12);
    chk("k9_code", 8'(key_code), 8'd9);
    chk("k9_vir", 8'(vir), 8'h02);
    chk("k9_hor", 8'(hor), 8'h00);
    col = 4'hF;
    step(12);
    chk("k9_rel_row", 8'(row), 8'h07);
    step(8);
    chk("k4_row1", 8'(row), 8'h0D);

    // Key 4: row 1, col 0, with a bounce during release.
    col = 4'b1110;
    step(12);
    chk("k4_kv", 8'(key_valid), 8'h01);
    chk("k4_code", 8'(key_code), 8'd4);
    chk("k4_vir", 8'(vir), 8'h00);
    chk("k4_hor", 8'(hor), 8'h01);
    col = 4'hF;
    step(4);
    col = 4'b1110;
    step(4);
    chk("k4_bounce_row", 8'(row), 8'h0D);
    col = 4'hF;
    step(12);
    chk("k4_rel_row", 8'(row), 8'h0B);
    chk("k4_pulses", 8'(pulses), 8'd4);
    chk("k4_hor_keep", 8'(hor), 8'h01);

    // Reset during debounce of key 6.
    step(12);
    chk("k6_row1", 8'(row), 8'h0D);
    col = 4'b1011;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("mr_row", 8'(row), 8'h0E);
    chk("mr_hor", 8'(hor), 8'h00);
    chk("mr_vir", 8'(vir), 8'h00);
    chk("mr_code", 8'(key_code), 8'h00);
    chk("mr_kv", 8'(key_valid), 8'h00);
    col = 4'hF;
    @(negedge clk) rst_n = 1'b1;
    step(4);
    chk("mr_row1", 8'(row), 8'h0D);
    step(20);
    chk("mr_row_after", 8'(row), 8'h0B);
    chk("mr_hor_after", 8'(hor), 8'h00);
    chk("mr_pulses", 8'(pulses), 8'd4);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Key 4 held: first pulse, then one every 96 cycles.
    step(12);
    chk("ar_row1", 8'(row), 8'h0D);
    col = 4'b1110;
    step(12);
    chk("ar_kv0", 8'(key_valid), 8'h01);
    chk("ar_code0", 8'(key_code), 8'd4);
    chk("ar_hor0", 8'(hor), 8'h01);
    step(1);
    chk("ar_kv0_off", 8'(key_valid), 8'h00);
    step(94);
    chk("ar_kv1_early", 8'(key_valid), 8'h00);
    step(1);
    chk("ar_kv1", 8'(key_valid), 8'h01);
    chk("ar_code1", 8'(key_code), 8'd4);
    chk("ar_hor1", 8'(hor), 8'h01);
    step(1);
    chk("ar_kv1_off", 8'(key_valid), 8'h00);
    step(95);
    chk("ar_kv2", 8'(key_valid), 8'h01);
    chk("ar_hor2", 8'(hor), 8'h01);
    chk("ar_pulses", 8'(pulses), 8'd7);
    col = 4'hF;
    step(16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
